// File: rtl/clk_div_gen.sv
// Purpose  : programmable multi-channel clock divider with lock emulation,
//            glitch-free ratio updates on period boundaries and phase sync.
// Latency  : clk_o/stb_o are decoded from registered state; a ratio update
//            takes effect at the channel's next period wrap (or next sync).
// Backpressure: cfg_ready_o drops while the addressed channel already holds
//            an unapplied ratio; it rises again the cycle after that wrap.
//
// Ports:
//   sys_clk_i      single clock, all state changes on its rising edge
//   reset_async_i  asynchronous active-high reset
//   cfg_valid_i    divide-update request
//   cfg_ready_o    update can be accepted this cycle
//   cfg_ch_i       target channel (out-of-range ids are accepted and dropped)
//   cfg_div_i      new divide ratio (values below 2 are clamped to 2)
//   sync_i         restart every channel's period on the next edge
//   clk_o          divided clock per channel
//   stb_o          one-cycle end-of-period strobe per channel
//   ready_o        outputs valid (rises LOCK_CYCLES edges after reset release)
module clk_div_gen #(
  parameter  int NUM_CH      = 4,
  parameter  int DIV_W       = 8,
  parameter  int LOCK_CYCLES = 16,
  parameter  int DIV_RESET   = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              sys_clk_i,
  input  logic              reset_async_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] clk_o,
  output logic [NUM_CH-1:0] stb_o,
  output logic              ready_o
);

  localparam int               LK_W      = $clog2(LOCK_CYCLES + 1);
  localparam logic [LK_W-1:0]  LOCK_LAST = LK_W'(LOCK_CYCLES - 1);
  localparam logic [LK_W-1:0]  LK_ONE    = LK_W'(1);
  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  // ---------------------------------------------------------------------
  // Lock emulation: count edges after reset release, then latch ready.
  // ---------------------------------------------------------------------
  logic [LK_W-1:0] lock_cnt;
  logic            ready_q;

  always_ff @(posedge sys_clk_i or posedge reset_async_i) begin
    if (reset_async_i) begin
      lock_cnt <= '0;
      ready_q  <= 1'b0;
    end else if (!ready_q) begin
      lock_cnt <= lock_cnt + LK_ONE;
      // lock_cnt still holds the previous edge count here, so this edge is
      // the LOCK_CYCLES-th one.
      if (lock_cnt == LOCK_LAST) begin
        ready_q <= 1'b1;
      end
    end
  end

  assign ready_o = ready_q;

  // ---------------------------------------------------------------------
  // Config decode. A one-hot select avoids indexing past NUM_CH when the
  // channel id is out of range: such writes select nothing and are dropped.
  // ---------------------------------------------------------------------
  logic [NUM_CH-1:0] ch_sel;
  logic [NUM_CH-1:0] pf_vec;
  logic              pf_hit;
  logic              cfg_accept;
  logic [DIV_W-1:0]  div_clamped;

  always_comb begin
    ch_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel[i] = (cfg_ch_i == CH_W'(i));
    end
  end

  assign pf_hit      = |(ch_sel & pf_vec);
  assign cfg_ready_o = ready_q & ~pf_hit;
  assign cfg_accept  = cfg_valid_i & cfg_ready_o;
  assign div_clamped = (cfg_div_i < DIV_MIN) ? DIV_MIN : cfg_div_i;

  // ---------------------------------------------------------------------
  // Per-channel divider: effective ratio, phase counter, pending ratio.
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] d_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] p_r;
    logic             pf_r;
    logic             wrap;

    assign wrap = (cnt_r == (d_r - DIV_ONE));

    always_ff @(posedge sys_clk_i or posedge reset_async_i) begin
      if (reset_async_i) begin
        d_r   <= DIV_RST;
        cnt_r <= '0;
        p_r   <= DIV_RST;
        pf_r  <= 1'b0;
      end else if (ready_q) begin
        // Sync and wrap both start a fresh period; a ratio that was already
        // pending is applied here so the change lands on a period boundary.
        if (sync_i || wrap) begin
          cnt_r <= '0;
          if (pf_r) begin
            d_r  <= p_r;
            pf_r <= 1'b0;
          end
        end else begin
          cnt_r <= cnt_r + DIV_ONE;
        end
        // Acceptance requires pf_r==0, so this never collides with the apply
        // above; a write landing on a wrap/sync edge waits for the next wrap.
        if (cfg_accept && ch_sel[g]) begin
          p_r  <= div_clamped;
          pf_r <= 1'b1;
        end
      end
    end

    assign pf_vec[g] = pf_r;
    assign clk_o[g]  = ready_q & (cnt_r < (d_r >> 1));
    assign stb_o[g]  = ready_q & wrap;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Purpose  : self-checking bench for clk_div_gen (3 channels, 8-bit ratios).
// Latency  : inputs driven on the falling edge, outputs sampled 1 time unit later.
// Backpressure: update writes are retried until cfg_ready is seen high.
module tb_clk_div_gen;

  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 16;
  localparam int DIV_RESET   = 2;
  localparam int CH_W        = 2;

  logic              sys_clk   = 1'b0;
  logic              rst       = 1'b1;
  logic              cfg_valid = 1'b0;
  logic [CH_W-1:0]   cfg_ch    = '0;
  logic [DIV_W-1:0]  cfg_div   = '0;
  logic              sync      = 1'b0;
  logic              cfg_ready;
  logic              ready;
  logic [NUM_CH-1:0] clk_div;
  logic [NUM_CH-1:0] stb;

  int checks = 0;
  int errors = 0;

  clk_div_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES), .DIV_RESET(DIV_RESET)
  ) dut (
    .sys_clk_i(sys_clk), .reset_async_i(rst), .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready), .cfg_ch_i(cfg_ch), .cfg_div_i(cfg_div),
    .sync_i(sync), .clk_o(clk_div), .stb_o(stb), .ready_o(ready)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- reference model (period position + pending queue) ----
  int m_ratio [NUM_CH];
  int m_pos   [NUM_CH];
  int m_pend  [NUM_CH][$];
  int m_edges;
  bit m_ready;

  function automatic void model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_ratio[i] = DIV_RESET;
      m_pos[i]   = 0;
      m_pend[i].delete();
    end
    m_edges = 0;
    m_ready = 1'b0;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_clk();
    logic [NUM_CH-1:0] r = '0;
    for (int i = 0; i < NUM_CH; i++) r[i] = m_ready && (m_pos[i] < m_ratio[i] / 2);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_stb();
    logic [NUM_CH-1:0] r = '0;
    for (int i = 0; i < NUM_CH; i++) r[i] = m_ready && (m_pos[i] == m_ratio[i] - 1);
    return r;
  endfunction

  function automatic bit exp_cfg_rdy(input int ch);
    if (!m_ready) return 1'b0;
    if (ch >= NUM_CH) return 1'b1;
    return m_pend[ch].size() == 0;
  endfunction

  function automatic void model_edge(input bit v, input int ch, input int dv, input bit s);
    bit acc = v && exp_cfg_rdy(ch);
    if (!m_ready) begin
      m_edges++;
      if (m_edges == LOCK_CYCLES) m_ready = 1'b1;
      return;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (s || m_pos[i] == m_ratio[i] - 1) begin
        m_pos[i] = 0;
        if (m_pend[i].size() > 0) m_ratio[i] = m_pend[i].pop_front();
      end else begin
        m_pos[i]++;
      end
    end
    if (acc && ch < NUM_CH) m_pend[ch].push_back(dv < 2 ? 2 : dv);
  endfunction

  // ---------------- checking helpers -------------------------------------
  logic [NUM_CH-1:0] obs_clk, obs_stb;
  logic              obs_rdy, obs_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive on the falling edge, sample, compare with model,
  // then advance the model on the rising edge.
  task automatic cycle(input bit v, input int ch, input int dv, input bit s);
    @(negedge sys_clk);
    cfg_valid = v;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(dv);
    sync      = s;
    #1;
    obs_clk   = clk_div;
    obs_stb   = stb;
    obs_rdy   = cfg_ready;
    obs_ready = ready;
    chk("model_ready", obs_ready, m_ready);
    chk("model_clk", obs_clk, exp_clk());
    chk("model_stb", obs_stb, exp_stb());
    chk("model_cfg_ready", obs_rdy, exp_cfg_rdy(ch));
    @(posedge sys_clk);
    model_edge(v, ch, dv, s);
  endtask

  // Called right after cycle() returns (at a rising edge): asserts reset
  // between edges and checks the outputs clear without any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_clk", clk_div, 0);
    chk("rst_stb", stb, 0);
    model_reset();
    repeat (2) @(posedge sys_clk);
    #2 rst = 1'b0;
  endtask

  task automatic lock_seq();
    for (int k = 1; k <= LOCK_CYCLES; k++) begin
      cycle(0, 0, 0, 0);
      chk("lock_ready_low", obs_ready, 0);
      chk("lock_outs_low", {obs_clk, obs_stb}, 0);
    end
  endtask

  // ---------------- directed vectors --------------------------------------
  typedef struct {
    bit       v;
    int       ch;
    int       dv;
    bit       s;
    logic [2:0] eclk;
    logic [2:0] estb;
    bit       erdy;
  } vec_t;

  vec_t tbl [8];

  logic [2:0] sync_clk [9] = '{3'b111, 3'b110, 3'b111, 3'b100, 3'b001,
                               3'b000, 3'b011, 3'b000, 3'b101};
  logic [2:0] sync_stb [9] = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b000,
                               3'b011, 3'b000, 3'b101, 3'b010};
  logic [2:0] dflt_clk [6] = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b111, 3'b000};
  logic [2:0] dflt_stb [6] = '{3'b000, 3'b111, 3'b000, 3'b111, 3'b000, 3'b111};
  int         rat [3]      = '{4, 6, 8};

  initial begin
    bit acc;
    int n, stalls, gap;
    bit prev_stb2;
    logic [2:0] pat;

    // ch1 <- 5 at the first ready cycle; rows show the default 2-ratio
    // toggle followed by ch1's 1,1,0,0,0 pattern.
    tbl[0] = '{1'b1, 1, 5, 1'b0, 3'b111, 3'b000, 1'b1};
    tbl[1] = '{1'b0, 1, 0, 1'b0, 3'b000, 3'b111, 1'b0};
    tbl[2] = '{1'b0, 1, 0, 1'b0, 3'b111, 3'b000, 1'b1};
    tbl[3] = '{1'b0, 1, 0, 1'b0, 3'b010, 3'b101, 1'b1};
    tbl[4] = '{1'b0, 1, 0, 1'b0, 3'b101, 3'b000, 1'b1};
    tbl[5] = '{1'b0, 1, 0, 1'b0, 3'b000, 3'b101, 1'b1};
    tbl[6] = '{1'b0, 1, 0, 1'b0, 3'b101, 3'b010, 1'b1};
    tbl[7] = '{1'b0, 1, 0, 1'b0, 3'b010, 3'b101, 1'b1};

    // Reset state
    #1;
    chk("init_ready", ready, 0);
    chk("init_cfg_ready", cfg_ready, 0);
    chk("init_clk", clk_div, 0);
    chk("init_stb", stb, 0);
    model_reset();
    @(posedge sys_clk);
    #2 rst = 1'b0;

    // Lock delay, then the table
    lock_seq();
    for (int r = 0; r < 8; r++) begin
      cycle(tbl[r].v, tbl[r].ch, tbl[r].dv, tbl[r].s);
      chk("tbl_ready", obs_ready, 1);
      chk("tbl_clk", obs_clk, tbl[r].eclk);
      chk("tbl_stb", obs_stb, tbl[r].estb);
      chk("tbl_cfg_ready", obs_rdy, tbl[r].erdy);
    end

    // Backpressure: ch2 <- 200 then ch2 <- 3
    acc = 0; n = 0;
    while (!acc && n < 10) begin
      cycle(1, 2, 200, 0);
      acc = obs_rdy;
      n++;
    end
    chk("bp_first_accept", acc, 1);
    acc = 0; stalls = 0; prev_stb2 = 0;
    while (!acc && stalls < 400) begin
      cycle(1, 2, 3, 0);
      if (obs_rdy) acc = 1;
      else begin
        stalls++;
        prev_stb2 = obs_stb[2];
      end
    end
    chk("bp_second_accept", acc, 1);
    chk("bp_stalled", stalls >= 1, 1);
    chk("bp_accept_after_wrap", prev_stb2, 1);
    gap = 0;
    do begin
      cycle(0, 0, 0, 0);
      gap++;
    end while (!obs_stb[2] && gap < 300);
    chk("bp_period_200", gap, 199);
    gap = 0; pat = '0;
    do begin
      cycle(0, 0, 0, 0);
      pat[gap] = obs_clk[2];
      gap++;
    end while (!obs_stb[2] && gap < 3);
    chk("bp_period_3", gap, 3);
    chk("bp_stb_at_end", obs_stb[2], 1);
    chk("bp_clk_pattern_3", pat, 3'b001);

    // Ratios 4/6/8, then clamp write on ch0 and a sync
    for (int j = 0; j < 3; j++) begin
      acc = 0; n = 0;
      while (!acc && n < 20) begin
        cycle(1, j, rat[j], 0);
        acc = obs_rdy;
        n++;
      end
      chk("set_ratio_accept", acc, 1);
    end
    repeat (20) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("clamp_accept", obs_rdy, 1);
    cycle(1, 1, 3, 1);
    chk("sync_write_accept", obs_rdy, 1);
    for (int t = 0; t < 9; t++) begin
      cycle(0, 1, 0, 0);
      chk("sync_clk", obs_clk, sync_clk[t]);
      chk("sync_stb", obs_stb, sync_stb[t]);
      if (t == 0) chk("sync_write_pending", obs_rdy, 0);
    end

    // Out-of-range channel: accepted, nothing changes
    cycle(1, 3, 50, 0);
    chk("oor_accept", obs_rdy, 1);
    repeat (12) cycle(0, 0, 0, 0);

    // Reset mid-period with a pending update on ch2
    cycle(1, 2, 7, 0);
    chk("pre_rst_accept", obs_rdy, 1);
    cycle(0, 0, 0, 0);
    do_reset();
    lock_seq();
    for (int r = 0; r < 6; r++) begin
      cycle(0, 2, 0, 0);
      chk("post_rst_clk", obs_clk, dflt_clk[r]);
      chk("post_rst_stb", obs_stb, dflt_stb[r]);
      chk("post_rst_cfg_ready", obs_rdy, 1);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 9),
            $urandom_range(0, 49) == 0);
      if ($urandom_range(0, 799) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of divided-clock channels (1..16).
REQ-002 The block SHALL have parameter DIV_W, default 8, giving the divide-ratio width in bits.
REQ-003 The block SHALL have parameter LOCK_CYCLES, default 16, giving the sys_clk_i cycles from reset release to ready_o (>=1).
REQ-004 The block SHALL have parameter DIV_RESET, default 2, giving the divide ratio loaded into every channel at reset (>=2).
REQ-005 The block SHALL have port sys_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_async_i, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port cfg_valid_i, input, 1 bit: divide-update request.
REQ-008 The block SHALL have port cfg_ready_o, output, 1 bit: update request can be accepted this cycle.
REQ-009 The block SHALL have port cfg_ch_i, input, CH_W = max(1, clog2(NUM_CH)) bits: target channel.
REQ-010 The block SHALL have port cfg_div_i, input, DIV_W bits: new divide ratio.
REQ-011 The block SHALL have port sync_i, input, 1 bit: phase-align all channels.
REQ-012 The block SHALL have port clk_o, output, NUM_CH bits: divided clock per channel.
REQ-013 The block SHALL have port stb_o, output, NUM_CH bits: one-cycle end-of-period strobe per channel.
REQ-014 The block SHALL have port ready_o, output, 1 bit: outputs valid (lock emulation).

Function
REQ-015 Lock counter SHALL count sys_clk_i edges after reset release; ready_o SHALL rise on the LOCK_CYCLES-th edge and stay high until reset.
REQ-016 While ready_o=0, all channel counters SHALL hold 0 and clk_o, stb_o SHALL be 0.
REQ-017 Each channel SHALL hold effective ratio d, counter cnt (0..d-1), pending ratio p and pending flag pf.
REQ-018 While ready_o=1, cnt SHALL increment each cycle and wrap from d-1 to 0.
REQ-019 clk_o[i] SHALL be 1 exactly when cnt < floor(d/2), giving floor(d/2) high and ceil(d/2) low cycles per period.
REQ-020 stb_o[i] SHALL be 1 exactly when cnt == d-1.
REQ-021 clk_o and stb_o SHALL depend only on registered state, with no combinational path from any input.
REQ-022 cfg_ready_o SHALL equal ready_o AND NOT pf[cfg_ch_i]; for an out-of-range cfg_ch_i it SHALL equal ready_o.
REQ-023 On cfg_valid_i AND cfg_ready_o, the block SHALL set p to max(cfg_div_i, 2) and set pf for the addressed channel; an out-of-range channel SHALL be accepted and discarded.
REQ-024 At a channel's wrap (cnt == d-1 with pf=1), the block SHALL load d<=p, clear pf, and set cnt<=0, so the new ratio starts on a period boundary with no runt pulse.
REQ-025 An update accepted in the same cycle as its channel's wrap SHALL be applied at the following wrap, not the current one.
REQ-026 On sync_i=1 with ready_o=1, every channel SHALL set cnt<=0 next cycle and apply any pf that was already set; no stb_o SHALL be issued for the truncated period.
REQ-027 An update accepted in the same cycle as sync_i SHALL remain pending until the next wrap.
REQ-028 sync_i and cfg_valid_i SHALL be ignored while ready_o=0.

Reset
REQ-029 Asserting reset_async_i SHALL immediately (without a clock) force ready_o=0, cfg_ready_o=0, clk_o=0, stb_o=0, lock counter=0, cnt=0, d=DIV_RESET, pf=0.
REQ-030 Reset asserted mid-operation SHALL discard pending updates, and the LOCK_CYCLES delay SHALL restart from release.

Verification
REQ-031 The bench SHALL check lock: with LOCK_CYCLES=16, release reset -> ready_o rises on the 16th edge, and clk_o/stb_o are 0 before that.
REQ-032 The bench SHALL check the default ratio: DIV_RESET=2 -> every clk_o toggles 1,0,1,0 starting the first cycle after ready, with stb_o on each 0 cycle.
REQ-033 The bench SHALL check an odd ratio: write ch1 div=5 -> after the current wrap, clk_o[1] is 1,1,0,0,0 repeating and stb_o[1] pulses every 5th cycle.
REQ-034 The bench SHALL check backpressure: write ch2 div=200 then immediately ch2 div=3 -> second write stalls (cfg_ready_o=0) until the wrap, then is accepted; 3 takes effect at the next wrap.
REQ-035 The bench SHALL check clamping and out-of-range: write div=0 to ch0 -> ratio 2; with NUM_CH=3, write ch3 -> accepted, no channel changes.
REQ-036 The bench SHALL check sync and reset: with ratios 4/6/8, pulse sync_i -> all cnt=0 next cycle and clk_o=111 then; assert reset mid-period -> all outputs 0 with no clock edge.
